// File: rtl/flash_access_ctrl.sv
// Request sequencer between the CPU port and the flash array: validates requests,
// times flash reads and program operations, and serves repeat reads from a last-read buffer.
module flash_access_ctrl #(
  parameter int unsigned ADDR_LIMIT  = 16384,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned PROG_CYCLES = 8,
  parameter int unsigned WP_LIMIT    = 1024,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        wp_en,
  output logic        cpu_ack,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        busy,
  output logic [31:0] fl_addr,
  output logic [31:0] fl_wdata,
  output logic        fl_we,
  input  logic [31:0] fl_rdata,
  input  logic        fl_ready
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_BUSY, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      req_addr;
  logic             err_pend;
  logic             hit_pend;
  logic             buf_valid;
  logic [31:0]      buf_addr;
  logic [31:0]      buf_data;
  logic             req_err;
  logic             buf_hit;

  always_comb begin
    req_err = (cpu_addr[1:0] != 2'b00)
           || (cpu_addr >= 32'(ADDR_LIMIT))
           || (cpu_we && wp_en && (cpu_addr < 32'(WP_LIMIT)));
    buf_hit = buf_valid && (buf_addr == cpu_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      err_pend  <= 1'b0;
      hit_pend  <= 1'b0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
      fl_addr   <= '0;
      fl_wdata  <= '0;
      fl_we     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      fl_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_ack  <= 1'b1;
            busy     <= 1'b1;
            req_addr <= cpu_addr;
            err_pend <= 1'b0;
            hit_pend <= 1'b0;
            if (req_err) begin
              err_pend <= 1'b1;
              state    <= RESP;
            end else if (!cpu_we && buf_hit) begin
              hit_pend <= 1'b1;
              state    <= RESP;
            end else if (!cpu_we) begin
              fl_addr <= cpu_addr;
              cnt     <= CNT_W'(READ_LAT);
              state   <= RD_WAIT;
            end else begin
              fl_addr  <= cpu_addr;
              fl_wdata <= cpu_wdata;
              fl_we    <= 1'b1;
              cnt      <= CNT_W'(PROG_CYCLES - 1);
              state    <= WR_BUSY;
              if (buf_hit)
                buf_data <= cpu_wdata;
            end
          end
        end
        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (fl_ready) begin
            cpu_rdata <= fl_rdata;
            buf_valid <= 1'b1;
            buf_addr  <= req_addr;
            buf_data  <= fl_rdata;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b0;
            state     <= RESP;
          end
        end
        WR_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cpu_done <= 1'b1;
            cpu_err  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          // RESP spans the ack-to-done gap of short requests plus the done cycle itself,
          // which keeps the next acceptance at least two cycles after cpu_done.
          if (cpu_done) begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cpu_done <= 1'b1;
            cpu_err  <= err_pend;
            if (hit_pend)
              cpu_rdata <= buf_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_access_ctrl.sv
// Scoreboard bench for flash_access_ctrl: expectations queued per request, checked at cpu_done.
module tb_flash_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, wp_en, fl_ready;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_done, cpu_err, busy, fl_we;
  logic [31:0] cpu_rdata, fl_addr, fl_wdata;
  logic [31:0] fl_rdata;

  always #5 clk = ~clk;

  flash_access_ctrl #(
    .ADDR_LIMIT (16384),
    .READ_LAT   (1),
    .PROG_CYCLES(8),
    .WP_LIMIT   (1024),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .wp_en    (wp_en),
    .cpu_ack  (cpu_ack),
    .cpu_done (cpu_done),
    .cpu_err  (cpu_err),
    .cpu_rdata(cpu_rdata),
    .busy     (busy),
    .fl_addr  (fl_addr),
    .fl_wdata (fl_wdata),
    .fl_we    (fl_we),
    .fl_rdata (fl_rdata),
    .fl_ready (fl_ready)
  );

  // Flash model: one-cycle registered read; unwritten words read as {20'hA5000, word index}.
  logic [31:0] mem    [4096];
  bit          wr_vld [4096];
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  always @(posedge clk) begin
    if (fl_we) begin
      mem[fl_addr[13:2]]    <= fl_wdata;
      wr_vld[fl_addr[13:2]] <= 1'b1;
    end
    fl_rdata <= ovr_en ? ovr_data
              : (wr_vld[fl_addr[13:2]] ? mem[fl_addr[13:2]] : {20'hA5000, fl_addr[13:2]});
  end

  typedef struct {
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   done_cyc = 0;
  int   ack_n = 0;
  int   done_n = 0;
  int   we_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fl_we) we_n++;
    if (cpu_ack) begin
      ack_cyc = cyc;
      ack_n++;
    end
    if (cpu_done) begin
      done_cyc = cyc;
      done_n++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_latency", 32'(cyc - ack_cyc), 32'(e.lat));
        check("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
        if (e.chk_rd) check("cpu_rdata", cpu_rdata, e.rd);
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    while (!cpu_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!cpu_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wp, input int lat, input logic err,
                        input logic chk_rd, input logic [31:0] rd, input int stall);
    sb.push_back('{lat, err, chk_rd, rd});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; wp_en = wp;
    wait_ack();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; wp_en = 1'b0;
    if (stall > 0) begin
      @(negedge clk);
      fl_ready = 1'b0;
      ovr_en   = 1'b1;
      ovr_data = rd;
      repeat (stall) @(negedge clk);
      fl_ready = 1'b1;
    end
    wait_done();
    ovr_en = 1'b0;
  endtask

  initial begin
    int we0;
    logic [31:0] fa;
    int done1;
    int acks0;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    wp_en = 1'b0; fl_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {27'd0, cpu_ack, cpu_done, cpu_err, busy, fl_we}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_fl_addr", fl_addr, 32'd0);
    check("rst_fl_wdata", fl_wdata, 32'd0);
    rst_n = 1'b1;

    // Repeat read: miss then buffer hit with no new flash address
    we0 = we_n;
    do_req(1'b0, 32'h0000_0100, '0, 1'b0, 2, 1'b0, 1'b1, 32'hA500_0040, 0);
    fa = fl_addr;
    do_req(1'b0, 32'h0000_0100, '0, 1'b0, 1, 1'b0, 1'b1, 32'hA500_0040, 0);
    check("hit_fl_addr", fl_addr, fa);
    check("read_no_we", 32'(we_n - we0), 32'd0);

    // Reset in cycle 3 of a program operation; buffer must be invalidated
    do_req(1'b0, 32'h0000_0300, '0, 1'b0, 2, 1'b0, 1'b1, 32'hA500_00C0, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h0BAD_0BAD;
    wait_ack();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {27'd0, cpu_ack, cpu_done, cpu_err, busy, fl_we}, 32'd0);
    check("midrst_rdata", cpu_rdata, 32'd0);
    check("midrst_fl_addr", fl_addr, 32'd0);
    check("midrst_fl_wdata", fl_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    do_req(1'b0, 32'h0000_0300, '0, 1'b0, 2, 1'b0, 1'b1, 32'hA500_00C0, 0);

    // Write then read back, then write-through into the buffered word
    we0 = we_n;
    do_req(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 8, 1'b0, 1'b0, '0, 0);
    check("write_we_once", 32'(we_n - we0), 32'd1);
    do_req(1'b0, 32'h0000_2000, '0, 1'b0, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
    do_req(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 8, 1'b0, 1'b0, '0, 0);
    do_req(1'b0, 32'h0000_2000, '0, 1'b0, 1, 1'b0, 1'b1, 32'hCAFE_F00D, 0);

    // Rejections: misaligned, out of range, protected write
    we0 = we_n;
    do_req(1'b0, 32'h0000_0102, '0, 1'b0, 1, 1'b1, 1'b0, '0, 0);
    do_req(1'b0, 32'h0000_4000, '0, 1'b0, 1, 1'b1, 1'b0, '0, 0);
    do_req(1'b1, 32'h0000_0200, 32'h1111_1111, 1'b1, 1, 1'b1, 1'b0, '0, 0);
    do_req(1'b1, 32'h0000_03FC, 32'h1111_1111, 1'b1, 1, 1'b1, 1'b0, '0, 0);
    check("err_no_we", 32'(we_n - we0), 32'd0);

    // Boundaries that must be accepted
    do_req(1'b1, 32'h0000_0200, 32'h2222_2222, 1'b0, 8, 1'b0, 1'b0, '0, 0);
    do_req(1'b1, 32'h0000_0400, 32'h3333_3333, 1'b1, 8, 1'b0, 1'b0, '0, 0);
    check("ok_writes_we", 32'(we_n - we0), 32'd2);
    do_req(1'b0, 32'h0000_0400, '0, 1'b0, 2, 1'b0, 1'b1, 32'h3333_3333, 0);
    do_req(1'b0, 32'h0000_3FFC, '0, 1'b0, 2, 1'b0, 1'b1, 32'hA500_0FFF, 0);

    // fl_ready low for 5 cycles at capture time
    do_req(1'b0, 32'h0000_0800, '0, 1'b0, 7, 1'b0, 1'b1, 32'h5EED_0005, 5);

    // cpu_req held through a write: one ack, next ack 2 cycles after done
    sb.push_back('{8, 1'b0, 1'b0, 32'd0});
    sb.push_back('{8, 1'b0, 1'b0, 32'd0});
    acks0 = ack_n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1000; cpu_wdata = 32'h4444_4444;
    wait_ack();
    @(negedge clk);
    wait_done();
    done1 = done_cyc;
    check("held_single_ack", 32'(ack_n - acks0), 32'd1);
    @(negedge clk);
    wait_ack();
    check("held_reack_gap", 32'(ack_cyc - done1), 32'd2);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    wait_done();
    repeat (4) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
